// File: rtl/br_predictor.sv
// ---------------------------------------------------------------------------------------------
// br_predictor: dynamic branch predictor for the 5-stage RV32I pipeline.
//
// The IF-stage lookup is purely combinational: a direct-mapped BTB supplies the hit and the
// target. A direction source, chosen by STRATEGY, supplies the taken decision. The EX stage
// trains the tables at the clock edge with the resolved outcome. Lookup and training in the
// same cycle see the pre-update state.
//
// Parameters
//   IDX_W    log2 of entries in the BTB, local PHT, global PHT and chooser
//   GHR_W    global history length, must be <= IDX_W
//   STRATEGY direction source: 0 = PRED_NONE, 1 = PRED_LOC, 2 = PRED_GLB, 3 = PRED_BOTH
//   CNT_W    width of the saturating performance counters
//
// Ports
//   i_clk, i_rst_n        clock, asynchronous active-low reset
//   i_if_pc               fetch PC to look up
//   o_pred_hit            BTB valid and tag match
//   o_pred_taken          redirect decision (hit & direction)
//   o_pred_target         BTB target
//   o_loc_taken           local PHT vote
//   o_glb_taken           global PHT vote (gshare index)
//   i_upd_*               resolved control-flow instruction from EX
//   o_ghr                 global history register
//   o_br_cnt              resolved control-flow instruction count
//   o_mispred_cnt         misprediction count
// ---------------------------------------------------------------------------------------------
module br_predictor #(
  parameter int unsigned IDX_W    = 6,
  parameter int unsigned GHR_W    = 6,
  parameter logic [1:0]  STRATEGY = 2'd3,
  parameter int unsigned CNT_W    = 32
) (
  input  logic             i_clk,
  input  logic             i_rst_n,
  input  logic [31:0]      i_if_pc,
  output logic             o_pred_hit,
  output logic             o_pred_taken,
  output logic [31:0]      o_pred_target,
  output logic             o_loc_taken,
  output logic             o_glb_taken,
  input  logic             i_upd_vld,
  input  logic             i_upd_is_br,
  input  logic [31:0]      i_upd_pc,
  input  logic [31:0]      i_upd_target,
  input  logic             i_upd_taken,
  input  logic             i_upd_loc_taken,
  input  logic             i_upd_glb_taken,
  input  logic             i_upd_mispred,
  output logic [GHR_W-1:0] o_ghr,
  output logic [CNT_W-1:0] o_br_cnt,
  output logic [CNT_W-1:0] o_mispred_cnt
);

  localparam logic [1:0]  PRED_NONE = 2'd0;
  localparam logic [1:0]  PRED_LOC  = 2'd1;
  localparam logic [1:0]  PRED_GLB  = 2'd2;
  localparam logic [1:0]  PRED_BOTH = 2'd3;
  localparam int unsigned ENTRIES   = 1 << IDX_W;
  localparam int unsigned TAG_W     = 32 - IDX_W - 2;

  logic             r_btb_vld [ENTRIES];
  logic [TAG_W-1:0] r_btb_tag [ENTRIES];
  logic [31:0]      r_btb_tgt [ENTRIES];
  logic [1:0]       r_loc_pht [ENTRIES];
  logic [1:0]       r_glb_pht [ENTRIES];
  logic [1:0]       r_chooser [ENTRIES];
  logic [GHR_W-1:0] r_ghr;
  logic [CNT_W-1:0] r_br_cnt;
  logic [CNT_W-1:0] r_mispred_cnt;

  logic [IDX_W-1:0] w_if_idx;
  logic [IDX_W-1:0] w_if_gidx;
  logic [TAG_W-1:0] w_if_tag;
  logic [IDX_W-1:0] w_upd_idx;
  logic [IDX_W-1:0] w_upd_gidx;
  logic [TAG_W-1:0] w_upd_tag;
  logic             w_dir;
  logic             w_unused;

  function automatic logic [1:0] sat_step(input logic [1:0] cnt, input logic up);
    if (up) return (cnt == 2'd3) ? cnt : cnt + 2'd1;
    else    return (cnt == 2'd0) ? cnt : cnt - 2'd1;
  endfunction

  // PC bits [1:0] never matter for word-aligned fetch.
  assign w_unused = ^{i_if_pc[1:0], i_upd_pc[1:0]};

  assign w_if_idx   = i_if_pc[IDX_W+1:2];
  assign w_if_tag   = i_if_pc[31:IDX_W+2];
  assign w_if_gidx  = w_if_idx ^ IDX_W'(r_ghr);
  assign w_upd_idx  = i_upd_pc[IDX_W+1:2];
  assign w_upd_tag  = i_upd_pc[31:IDX_W+2];
  // Training uses the committed history; skew against the lookup index is accepted.
  assign w_upd_gidx = w_upd_idx ^ IDX_W'(r_ghr);

  assign o_pred_hit    = r_btb_vld[w_if_idx] && (r_btb_tag[w_if_idx] == w_if_tag);
  assign o_pred_target = r_btb_tgt[w_if_idx];
  assign o_loc_taken   = r_loc_pht[w_if_idx][1];
  assign o_glb_taken   = r_glb_pht[w_if_gidx][1];

  always_comb begin
    w_dir = 1'b1;
    case (STRATEGY)
      PRED_NONE: w_dir = 1'b1;
      PRED_LOC:  w_dir = o_loc_taken;
      PRED_GLB:  w_dir = o_glb_taken;
      PRED_BOTH: w_dir = r_chooser[w_if_idx][1] ? o_glb_taken : o_loc_taken;
      default:   w_dir = 1'b1;
    endcase
  end

  // No redirect without a target to go to.
  assign o_pred_taken = o_pred_hit & w_dir;

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < ENTRIES; i++) begin
        r_btb_vld[i] <= 1'b0;
        r_btb_tag[i] <= '0;
        r_btb_tgt[i] <= '0;
        r_loc_pht[i] <= 2'b01;
        r_glb_pht[i] <= 2'b01;
        r_chooser[i] <= 2'b01;
      end
      r_ghr         <= '0;
      r_br_cnt      <= '0;
      r_mispred_cnt <= '0;
    end else if (i_upd_vld) begin
      if (i_upd_taken) begin
        r_btb_vld[w_upd_idx] <= 1'b1;
        r_btb_tag[w_upd_idx] <= w_upd_tag;
        r_btb_tgt[w_upd_idx] <= i_upd_target;
      end
      if (i_upd_is_br) begin
        r_loc_pht[w_upd_idx]  <= sat_step(r_loc_pht[w_upd_idx], i_upd_taken);
        r_glb_pht[w_upd_gidx] <= sat_step(r_glb_pht[w_upd_gidx], i_upd_taken);
        // Train the chooser only when the votes disagree: exactly one of them was right.
        if (i_upd_loc_taken != i_upd_glb_taken) begin
          r_chooser[w_upd_idx] <= sat_step(r_chooser[w_upd_idx],
                                           i_upd_glb_taken == i_upd_taken);
        end
        r_ghr <= GHR_W'({r_ghr, i_upd_taken});
      end
      if (r_br_cnt != '1) r_br_cnt <= r_br_cnt + CNT_W'(1);
      if (i_upd_mispred && (r_mispred_cnt != '1)) begin
        r_mispred_cnt <= r_mispred_cnt + CNT_W'(1);
      end
    end
  end

  assign o_ghr         = r_ghr;
  assign o_br_cnt      = r_br_cnt;
  assign o_mispred_cnt = r_mispred_cnt;

endmodule

// File: tb/tb_br_predictor.sv
// Directed bench for br_predictor. Four instances share one set of inputs and differ only in
// STRATEGY / CNT_W: [0] PRED_LOC, [1] PRED_NONE, [2] PRED_BOTH, [3] PRED_BOTH with CNT_W=4.
module tb_br_predictor;

  logic        clk;
  logic        rst_n;
  logic [31:0] if_pc;
  logic        upd_vld, upd_is_br, upd_taken, upd_loc, upd_glb, upd_mispred;
  logic [31:0] upd_pc, upd_target;

  logic        hit [4];
  logic        taken [4];
  logic [31:0] target [4];
  logic        loc [4];
  logic        glb [4];
  logic [5:0]  ghr [4];
  logic [31:0] br_cnt [3];
  logic [31:0] mis_cnt [3];
  logic [3:0]  br4, mis4;

  int tests = 0;
  int fails = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  br_predictor #(.STRATEGY(2'd1)) u_loc (
    .i_clk(clk), .i_rst_n(rst_n), .i_if_pc(if_pc),
    .o_pred_hit(hit[0]), .o_pred_taken(taken[0]), .o_pred_target(target[0]),
    .o_loc_taken(loc[0]), .o_glb_taken(glb[0]),
    .i_upd_vld(upd_vld), .i_upd_is_br(upd_is_br), .i_upd_pc(upd_pc),
    .i_upd_target(upd_target), .i_upd_taken(upd_taken), .i_upd_loc_taken(upd_loc),
    .i_upd_glb_taken(upd_glb), .i_upd_mispred(upd_mispred),
    .o_ghr(ghr[0]), .o_br_cnt(br_cnt[0]), .o_mispred_cnt(mis_cnt[0])
  );

  br_predictor #(.STRATEGY(2'd0)) u_none (
    .i_clk(clk), .i_rst_n(rst_n), .i_if_pc(if_pc),
    .o_pred_hit(hit[1]), .o_pred_taken(taken[1]), .o_pred_target(target[1]),
    .o_loc_taken(loc[1]), .o_glb_taken(glb[1]),
    .i_upd_vld(upd_vld), .i_upd_is_br(upd_is_br), .i_upd_pc(upd_pc),
    .i_upd_target(upd_target), .i_upd_taken(upd_taken), .i_upd_loc_taken(upd_loc),
    .i_upd_glb_taken(upd_glb), .i_upd_mispred(upd_mispred),
    .o_ghr(ghr[1]), .o_br_cnt(br_cnt[1]), .o_mispred_cnt(mis_cnt[1])
  );

  br_predictor #(.STRATEGY(2'd3)) u_both (
    .i_clk(clk), .i_rst_n(rst_n), .i_if_pc(if_pc),
    .o_pred_hit(hit[2]), .o_pred_taken(taken[2]), .o_pred_target(target[2]),
    .o_loc_taken(loc[2]), .o_glb_taken(glb[2]),
    .i_upd_vld(upd_vld), .i_upd_is_br(upd_is_br), .i_upd_pc(upd_pc),
    .i_upd_target(upd_target), .i_upd_taken(upd_taken), .i_upd_loc_taken(upd_loc),
    .i_upd_glb_taken(upd_glb), .i_upd_mispred(upd_mispred),
    .o_ghr(ghr[2]), .o_br_cnt(br_cnt[2]), .o_mispred_cnt(mis_cnt[2])
  );

  br_predictor #(.STRATEGY(2'd3), .CNT_W(4)) u_cnt (
    .i_clk(clk), .i_rst_n(rst_n), .i_if_pc(if_pc),
    .o_pred_hit(hit[3]), .o_pred_taken(taken[3]), .o_pred_target(target[3]),
    .o_loc_taken(loc[3]), .o_glb_taken(glb[3]),
    .i_upd_vld(upd_vld), .i_upd_is_br(upd_is_br), .i_upd_pc(upd_pc),
    .i_upd_target(upd_target), .i_upd_taken(upd_taken), .i_upd_loc_taken(upd_loc),
    .i_upd_glb_taken(upd_glb), .i_upd_mispred(upd_mispred),
    .o_ghr(ghr[3]), .o_br_cnt(br4), .o_mispred_cnt(mis4)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  // One training cycle; returns 1 ns after the capturing edge.
  task automatic upd(input logic [31:0] pc, input logic [31:0] tgt, input logic tk,
                     input logic is_br, input logic lv, input logic gv, input logic mp);
    upd_pc = pc; upd_target = tgt; upd_taken = tk; upd_is_br = is_br;
    upd_loc = lv; upd_glb = gv; upd_mispred = mp; upd_vld = 1'b1;
    @(posedge clk);
    #1;
    upd_vld = 1'b0;
    upd_mispred = 1'b0;
  endtask

  initial begin
    rst_n = 1'b0; if_pc = 32'h100;
    upd_vld = 0; upd_is_br = 0; upd_taken = 0; upd_loc = 0; upd_glb = 0; upd_mispred = 0;
    upd_pc = '0; upd_target = '0;
    #12 rst_n = 1'b1;
    #1;

    // 1: reset state
    chk("rst_hit", {31'd0, hit[2]}, 32'd0);
    chk("rst_taken_none", {31'd0, taken[1]}, 32'd0);
    chk("rst_loc", {31'd0, loc[2]}, 32'd0);
    chk("rst_glb", {31'd0, glb[2]}, 32'd0);
    chk("rst_ghr", {26'd0, ghr[2]}, 32'd0);
    chk("rst_br_cnt", br_cnt[2], 32'd0);
    chk("rst_mis_cnt", mis_cnt[2], 32'd0);

    // 2: local training at 0x100 (idx 0, tag 1)
    upd(32'h100, 32'h80, 1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    if_pc = 32'h100; #1;
    chk("t2_hit", {31'd0, hit[0]}, 32'd1);
    chk("t2_loc", {31'd0, loc[0]}, 32'd1);
    chk("t2_taken_loc", {31'd0, taken[0]}, 32'd1);
    chk("t2_target", target[0], 32'h80);
    chk("t2_ghr", {26'd0, ghr[0]}, 32'd1);
    upd(32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    upd(32'h100, 32'h0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    #1;
    chk("t2_nt_hit", {31'd0, hit[0]}, 32'd1);
    chk("t2_nt_taken", {31'd0, taken[0]}, 32'd0);
    chk("t2_nt_target", target[0], 32'h80);
    chk("t2_ghr2", {26'd0, ghr[0]}, 32'd4);

    // 3: jal at 0x200 aliases idx 0 with tag 2 and replaces the 0x100 entry
    upd(32'h200, 32'h400, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    if_pc = 32'h200; #1;
    chk("t3_hit", {31'd0, hit[1]}, 32'd1);
    chk("t3_taken_none", {31'd0, taken[1]}, 32'd1);
    chk("t3_taken_loc", {31'd0, taken[0]}, 32'd0);
    chk("t3_target", target[1], 32'h400);
    chk("t3_ghr", {26'd0, ghr[1]}, 32'd4);
    if_pc = 32'h300; #1;
    chk("t3_tag_miss", {31'd0, hit[1]}, 32'd0);
    if_pc = 32'h100; #1;
    chk("t3_alias_miss", {31'd0, hit[1]}, 32'd0);

    // 4: global vote wins four times at 0x40 (idx 16); chooser saturates
    repeat (4) upd(32'h40, 32'h1000, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    if_pc = 32'h40; #1;
    chk("t4_ghr", {26'd0, ghr[2]}, 32'h0f);
    chk("t4_loc", {31'd0, loc[2]}, 32'd1);
    chk("t4_glb", {31'd0, glb[2]}, 32'd0);
    chk("t4_both_sel_glb", {31'd0, taken[2]}, 32'd0);
    chk("t4_loc_taken", {31'd0, taken[0]}, 32'd1);
    chk("t4_target", target[2], 32'h1000);
    chk("t4_br_cnt", br_cnt[2], 32'd8);
    chk("t4_mis_cnt", mis_cnt[2], 32'd2);

    // 5: same-cycle lookup and update of idx 16
    upd_pc = 32'h40; upd_target = 32'h2000; upd_taken = 1'b1; upd_is_br = 1'b1;
    upd_loc = 1'b1; upd_glb = 1'b1; upd_mispred = 1'b0; upd_vld = 1'b1;
    #2;
    chk("t5_old_target", target[2], 32'h1000);
    chk("t5_old_ghr", {26'd0, ghr[2]}, 32'h0f);
    chk("t5_old_br", br_cnt[2], 32'd8);
    @(posedge clk);
    #1;
    upd_vld = 1'b0;
    chk("t5_new_target", target[2], 32'h2000);
    chk("t5_new_ghr", {26'd0, ghr[2]}, 32'h1f);
    chk("t5_new_br", br_cnt[2], 32'd9);

    // 6: counter saturation at CNT_W=4, then asynchronous reset
    repeat (20) upd(32'h800, 32'h0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1);
    chk("t6_br4_sat", {28'd0, br4}, 32'd15);
    chk("t6_mis4_sat", {28'd0, mis4}, 32'd15);
    chk("t6_br32", br_cnt[2], 32'd29);
    chk("t6_mis32", mis_cnt[2], 32'd22);
    if_pc = 32'h40;
    upd_pc = 32'h40; upd_taken = 1'b1; upd_is_br = 1'b1; upd_vld = 1'b1; upd_mispred = 1'b1;
    #2;
    chk("t6_pre_rst_hit", {31'd0, hit[2]}, 32'd1);
    rst_n = 1'b0;
    #1;
    chk("t6_rst_hit", {31'd0, hit[2]}, 32'd0);
    chk("t6_rst_taken", {31'd0, taken[1]}, 32'd0);
    chk("t6_rst_loc", {31'd0, loc[2]}, 32'd0);
    chk("t6_rst_ghr", {26'd0, ghr[2]}, 32'd0);
    chk("t6_rst_br4", {28'd0, br4}, 32'd0);
    chk("t6_rst_mis4", {28'd0, mis4}, 32'd0);
    chk("t6_rst_br32", br_cnt[2], 32'd0);
    upd_vld = 1'b0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/br_predictor.md
Name: br_predictor

Overview:
- Parametrised dynamic branch predictor for the 5-stage RV32I pipeline. It replaces the fixed always-taken scheme.
- IF stage: combinational lookup of the current PC. It returns BTB hit, taken decision, target, and the raw local/global votes that feed the IF/ID prediction fields (pred_taken, pred_hit, glb_taken, loc_taken).
- EX stage: registered training with the resolved outcome.
- Strategy is selectable (none/local/global/both), and table depth and history length are configurable.

Parameters:
- IDX_W, 6: log2 of entries in the BTB, local PHT, global PHT and chooser. Index = pc[IDX_W+1:2].
- GHR_W, 6: global history length in bits. Must satisfy GHR_W <= IDX_W.
- STRATEGY, PRED_BOTH: PreStrategy_e value selecting the direction source.
- CNT_W, 32: width of the performance counters.

Ports:
- i_clk  in  1  clock
- i_rst_n  in  1  reset
- i_if_pc  in  32  fetch PC, word aligned
- o_pred_hit  out  1  BTB valid and tag match for i_if_pc
- o_pred_taken  out  1  final redirect decision
- o_pred_target  out  32  BTB target; don't-care when o_pred_hit=0
- o_loc_taken  out  1  local PHT msb at the PC index
- o_glb_taken  out  1  global PHT msb at index (PC index XOR zero-extended GHR)
- i_upd_vld  in  1  EX resolves a branch/jump this cycle
- i_upd_is_br  in  1  1 = conditional branch, 0 = jal/jalr
- i_upd_pc  in  32  PC of the resolved instruction
- i_upd_target  in  32  resolved taken target
- i_upd_taken  in  1  actual outcome
- i_upd_loc_taken  in  1  local vote carried down the pipe
- i_upd_glb_taken  in  1  global vote carried down the pipe
- i_upd_mispred  in  1  EX flushed due to this instruction
- o_ghr  out  GHR_W  current global history, for debug
- o_br_cnt  out  CNT_W  resolved control-flow instructions
- o_mispred_cnt  out  CNT_W  mispredictions

Clocking and reset: One clock, i_clk. Reset i_rst_n is asynchronous, active-low.

Behaviour:
- Storage is flop arrays, all asynchronously reset. Reset values:
  - BTB valid = 0
  - local and global PHT counters = 2'b01 (weakly not-taken)
  - chooser = 2'b01 (weakly prefers local)
  - GHR = 0
  - both perf counters = 0
- Resulting outputs at reset: o_pred_hit=0, o_pred_taken=0, o_loc_taken=0, o_glb_taken=0, o_ghr=0, o_br_cnt=0, o_mispred_cnt=0.
- Lookup is purely combinational from i_if_pc and the current state, with zero latency.
  - Tag = pc[31:IDX_W+2]; hit = valid & tag equal.
- Direction selection:
  - PRED_NONE: dir=1.
  - PRED_LOC: dir=local msb.
  - PRED_GLB: dir=global msb.
  - PRED_BOTH: dir = chooser msb ? global msb : local msb.
- o_pred_taken = hit & dir. There is no redirect without a BTB target.
- All updates happen at the posedge when i_upd_vld=1. Nothing changes when i_upd_vld=0.
  - Indices are recomputed from i_upd_pc using the GHR value before this update. The GHR is non-speculative; the resulting index skew versus lookup is accepted.
- BTB update: when i_upd_taken=1, write valid=1, tag and i_upd_target (allocate or overwrite). When not taken, the entry is unchanged.
- PHT update (i_upd_is_br=1 only): the local and global counters saturate +1 if taken and -1 if not, clamped at 0 and 3.
- Jumps (i_upd_is_br=0): write the BTB only. The PHTs, chooser and GHR are untouched.
- Chooser update (branch only, and only when i_upd_loc_taken != i_upd_glb_taken):
  - +1 saturating if the global vote equals the outcome.
  - -1 saturating if the local vote equals the outcome.
- GHR update (branch only): {ghr[GHR_W-2:0], i_upd_taken}.
- Perf counters:
  - o_br_cnt +1 per i_upd_vld.
  - o_mispred_cnt +1 when i_upd_vld & i_upd_mispred.
  - Both saturate at all-ones; they do not wrap.
  - i_upd_mispred is ignored when i_upd_vld=0.
- Same-cycle lookup and update of the same entry: the lookup returns the pre-update value. There is no bypass; the new value is visible the next cycle.
- Reset asserted mid-operation clears everything immediately, and the outputs revert to their reset values combinationally.
- PC bits [1:0] are ignored.
- Aliasing across different tags at the same index: the last taken writer wins.

Test Plan:
1. Reset, then lookup pc=0x100 -> hit=0, taken=0, loc=0, glb=0, ghr=0, counters 0.
2. STRATEGY=PRED_LOC. Update branch pc=0x100, taken, target=0x80, once. Then lookup 0x100 the next cycle -> hit=1, loc=1 (counter 2), taken=1, target=0x80. Two not-taken updates -> taken=0, hit stays 1.
3. Jal update pc=0x200, target=0x400 -> next-cycle hit=1, taken=1 under PRED_NONE; ghr unchanged. Lookup 0x200+(1<<(IDX_W+2)) -> hit=0 (tag mismatch).
4. PRED_BOTH. Four branch updates with loc_taken=0, glb_taken=1, taken=1 at pc=0x40 -> chooser saturates at 3, ghr=6'b001111. Lookup selects the global vote.
5. Drive i_upd_vld with the same index as the lookup in the same cycle -> outputs show old state that cycle and new state the next cycle.
6. CNT_W=4. 20 updates with mispred=1 -> o_br_cnt=o_mispred_cnt=15 (saturated). Assert i_rst_n=0 mid-sequence -> all outputs 0 with no clock edge.
